pwm_medidor: RTL and testbench

Receive-side counterpart of `pwm_generador`: samples a PWM waveform, measures its high time over fixed windows of one PWM period and reports the duty cycle as a tenths value 0–10. This is the same scale the generator accepts on `switch`, with requests above 10 capped at 10. It sits at the board input of a PWM link, or loops back from the generator's `led` output for self-check, and drives status LEDs or downstream logic.

---
 rtl/pwm_pkg.sv | 25 ++
 rtl/sincronizador.sv | 39 +++
 rtl/pwm_medidor.sv | 156 +++++++++++++++
 tb/tb_pwm_medidor.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared by the PWM link blocks (generator and meter).
//   DUTY_MAX : largest duty value in tenths; larger requests saturate here
//   DUTY_W   : width of a duty value
//   estado_t : state encoding of the duty quantiser FSM
`timescale 1ns / 1ps
package pwm_pkg;

   localparam int unsigned DUTY_MAX = 10;
   localparam int unsigned DUTY_W   = 4;

   typedef enum logic [1:0] {
      IDLE,
      QUANT,
      DONE
   } estado_t;

   // Clamp a duty request to the 0..DUTY_MAX range.
   function automatic logic [DUTY_W-1:0] sat_duty(input logic [DUTY_W-1:0] req);
      if (req > DUTY_W'(DUTY_MAX)) begin
         return DUTY_W'(DUTY_MAX);
      end
      return req;
   endfunction

endpackage

// File: rtl/sincronizador.sv
// sincronizador: two-flop synchronizer for an asynchronous input, with
// single-cycle rise/fall pulses derived from the synchronized level.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   i_async  : asynchronous input (PWM line, switch, button)
//   o_sync   : synchronized level, 2 cycles behind i_async
//   o_rise   : one-cycle pulse on a 0->1 change of o_sync
//   o_fall   : one-cycle pulse on a 1->0 change of o_sync
`timescale 1ns / 1ps
module sincronizador (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_sync = r_sync;
   assign o_rise = r_sync & ~r_prev;
   assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/pwm_medidor.sv
// pwm_medidor: measures the duty cycle of an incoming PWM waveform.
// High time is counted over back-to-back windows of PERIOD_CYCLES clocks and
// quantised to tenths (round half up, saturated at DUTY_MAX).
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   pwm_in     : asynchronous PWM input
//   duty       : last measured duty in tenths, 0..10
//   duty_valid : one-cycle pulse when duty is updated
//   activo     : pwm_in had at least one edge in the last completed window
`timescale 1ns / 1ps
module pwm_medidor
   import pwm_pkg::*;
#(
   parameter int unsigned PERIOD_CYCLES = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pwm_in,
   output logic [DUTY_W-1:0] duty,
   output logic              duty_valid,
   output logic              activo
);

   localparam int unsigned CNT_W = $clog2(PERIOD_CYCLES + 1);
   localparam int unsigned STEP  = PERIOD_CYCLES / 10;
   // The threshold runs up to STEP/2 + 10*STEP, beyond PERIOD_CYCLES.
   localparam int unsigned THR_W = $clog2(PERIOD_CYCLES + STEP + 1);

   localparam logic [CNT_W-1:0]  WIN_LAST = CNT_W'(PERIOD_CYCLES - 1);
   localparam logic [THR_W-1:0]  THR_INIT = THR_W'(STEP / 2);
   localparam logic [THR_W-1:0]  THR_STEP = THR_W'(STEP);
   localparam logic [DUTY_W-1:0] K_MAX    = DUTY_W'(DUTY_MAX);

   // Quantisation takes up to 12 cycles and must finish inside one window.
   if ((PERIOD_CYCLES % 10) != 0 || PERIOD_CYCLES < 20) begin : g_bad_period
      $error("pwm_medidor: PERIOD_CYCLES must be a multiple of 10 and at least 20");
   end

   // Input conditioning
   logic w_pwm_s;
   logic w_rise;
   logic w_fall;
   logic w_edge;

   sincronizador u_sinc (
      .clk     (clk),
      .rst     (rst),
      .i_async (pwm_in),
      .o_sync  (w_pwm_s),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   assign w_edge = w_rise | w_fall;

   // Window counter and high-time accumulation
   logic [CNT_W-1:0] r_win_cnt;
   logic [CNT_W-1:0] r_high_cnt;
   logic             r_edge_seen;
   logic [CNT_W-1:0] r_capture;
   logic             r_activo;
   logic             w_win_end;

   assign w_win_end = (r_win_cnt == WIN_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_win_cnt   <= '0;
         r_high_cnt  <= '0;
         r_edge_seen <= 1'b0;
         r_capture   <= '0;
         r_activo    <= 1'b0;
      end else if (w_win_end) begin
         // The sample and edge of the last cycle still belong to this window.
         r_win_cnt   <= '0;
         r_high_cnt  <= '0;
         r_edge_seen <= 1'b0;
         r_capture   <= r_high_cnt + CNT_W'(w_pwm_s);
         r_activo    <= r_edge_seen | w_edge;
      end else begin
         r_win_cnt   <= r_win_cnt + CNT_W'(1);
         r_high_cnt  <= r_high_cnt + CNT_W'(w_pwm_s);
         r_edge_seen <= r_edge_seen | w_edge;
      end
   end

   // Quantiser: walk the thresholds STEP/2, 3*STEP/2, ... until capture drops
   // below one; the number passed is the rounded duty.
   estado_t           r_state;
   estado_t           w_state_next;
   logic [DUTY_W-1:0] r_k;
   logic [DUTY_W-1:0] w_k_next;
   logic [THR_W-1:0]  r_thr;
   logic [THR_W-1:0]  w_thr_next;
   logic [DUTY_W-1:0] r_duty;
   logic [DUTY_W-1:0] w_duty_next;
   logic              r_valid;
   logic              w_valid_next;
   logic [THR_W-1:0]  w_cap_ext;

   assign w_cap_ext = THR_W'(r_capture);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_k     <= '0;
         r_thr   <= '0;
         r_duty  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_k     <= w_k_next;
         r_thr   <= w_thr_next;
         r_duty  <= w_duty_next;
         r_valid <= w_valid_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_k_next     = r_k;
      w_thr_next   = r_thr;
      w_duty_next  = r_duty;
      w_valid_next = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_win_end) begin
               w_state_next = QUANT;
               w_k_next     = '0;
               w_thr_next   = THR_INIT;
            end
         end
         QUANT: begin
            if (w_cap_ext >= r_thr && r_k < K_MAX) begin
               w_k_next   = r_k + DUTY_W'(1);
               w_thr_next = r_thr + THR_STEP;
            end else begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            w_duty_next  = r_k;
            w_valid_next = 1'b1;
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign duty       = r_duty;
   assign duty_valid = r_valid;
   assign activo     = r_activo;

endmodule

// File: tb/tb_pwm_medidor.sv
`timescale 1ns / 1ps
module tb_pwm_medidor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pwm_in = 1'b0;
   logic [3:0] duty;
   logic       duty_valid;
   logic       activo;

   int n_checks = 0;
   int n_fail   = 0;

   // PWM source settings: high cycles per 1000-cycle period
   int tb_high   = 0;
   bit gen_start = 1'b0;
   bit jitter_en = 1'b0;
   int gen_h;

   always #5 clk = ~clk;

   pwm_medidor #(
      .PERIOD_CYCLES (1000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pwm_in     (pwm_in),
      .duty       (duty),
      .duty_valid (duty_valid),
      .activo     (activo)
   );

   // Periodic PWM source; the setting is latched at each period start.
   // Edges land mid-cycle, optionally jittered by +/-3 ns.
   initial begin
      wait (gen_start);
      forever begin
         gen_h = tb_high;
         for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            if (jitter_en) #(2 + $urandom_range(0, 6));
            else #5;
            pwm_in = (i < gen_h);
         end
      end
   end

   task automatic wait_valid(output bit got, output int cycles);
      got    = 1'b0;
      cycles = 0;
      while (!got && cycles < 1100) begin
         @(negedge clk);
         cycles++;
         if (duty_valid === 1'b1) got = 1'b1;
      end
   endtask

   task automatic wait_pulses(input int n, output bit got);
      int cyc;
      got = 1'b1;
      for (int k = 0; k < n && got; k++) wait_valid(got, cyc);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (duty !== 4'd0) begin
         n_fail++; $display("FAIL reset_duty: got %0d, expected 0", duty);
      end
      n_checks++;
      if (duty_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid: got %0b, expected 0", duty_valid);
      end
      n_checks++;
      if (activo !== 1'b0) begin
         n_fail++; $display("FAIL reset_activo: got %0b, expected 0", activo);
      end
   endtask

   task automatic test_first_window();
      bit got;
      int cyc;
      rst = 1'b0;
      wait_valid(got, cyc);
      n_checks++;
      if (!got || cyc < 1000 || cyc > 1012) begin
         n_fail++; $display("FAIL first_valid_latency: got %0d cycles, expected 1000..1012", cyc);
      end
      wait_valid(got, cyc);
      n_checks++;
      if (!got || cyc != 1000) begin
         n_fail++; $display("FAIL valid_period: got %0d cycles, expected 1000", cyc);
      end
      n_checks++;
      if (duty !== 4'd1) begin
         n_fail++; $display("FAIL duty_10pct: got %0d, expected 1", duty);
      end
      n_checks++;
      if (activo !== 1'b1) begin
         n_fail++; $display("FAIL activo_10pct: got %0b, expected 1", activo);
      end
      @(negedge clk);
      n_checks++;
      if (duty_valid !== 1'b0) begin
         n_fail++; $display("FAIL valid_single_cycle: got %0b, expected 0", duty_valid);
      end
   endtask

   task automatic test_duty_levels();
      int hi_tab[8] = '{400, 800, 149, 150, 50, 49, 950, 949};
      int ex_tab[8] = '{4, 8, 1, 2, 1, 0, 10, 9};
      bit got;
      for (int v = 0; v < 8; v++) begin
         tb_high = hi_tab[v];
         wait_pulses(3, got);
         n_checks++;
         if (!got || duty !== 4'(ex_tab[v])) begin
            n_fail++;
            $display("FAIL duty_high_%0d: got %0d (valid seen %0b), expected %0d",
                     hi_tab[v], duty, got, ex_tab[v]);
         end
         n_checks++;
         if (activo !== 1'b1) begin
            n_fail++; $display("FAIL activo_high_%0d: got %0b, expected 1", hi_tab[v], activo);
         end
      end
   endtask

   task automatic test_constant();
      bit got;
      int cyc;
      tb_high = 0;
      wait_pulses(3, got);
      n_checks++;
      if (!got || duty !== 4'd0) begin
         n_fail++; $display("FAIL const_low_duty: got %0d (valid seen %0b), expected 0", duty, got);
      end
      n_checks++;
      if (activo !== 1'b0) begin
         n_fail++; $display("FAIL const_low_activo: got %0b, expected 0", activo);
      end
      tb_high = 1000;
      wait_pulses(3, got);
      n_checks++;
      if (!got || duty !== 4'd10) begin
         n_fail++; $display("FAIL const_high_duty: got %0d (valid seen %0b), expected 10", duty, got);
      end
      n_checks++;
      if (activo !== 1'b0) begin
         n_fail++; $display("FAIL const_high_activo: got %0b, expected 0", activo);
      end
      wait_valid(got, cyc);
      n_checks++;
      if (!got || cyc != 1000) begin
         n_fail++; $display("FAIL const_high_period: got %0d cycles, expected 1000", cyc);
      end
      // duty must hold between pulses
      repeat (500) @(negedge clk);
      n_checks++;
      if (duty !== 4'd10) begin
         n_fail++; $display("FAIL const_high_hold: got %0d, expected 10", duty);
      end
   endtask

   task automatic test_reset_mid();
      bit got;
      int cyc;
      tb_high = 800;
      wait_pulses(3, got);
      n_checks++;
      if (!got || duty !== 4'd8) begin
         n_fail++; $display("FAIL pre_reset_duty: got %0d, expected 8", duty);
      end
      repeat (488) @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (duty !== 4'd0 || duty_valid !== 1'b0 || activo !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: got duty=%0d valid=%0b activo=%0b, expected all 0",
                  duty, duty_valid, activo);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      wait_valid(got, cyc);
      n_checks++;
      if (!got || cyc < 1000 || cyc > 1012) begin
         n_fail++; $display("FAIL post_reset_latency: got %0d cycles, expected 1000..1012", cyc);
      end
      n_checks++;
      if (duty !== 4'd8) begin
         n_fail++; $display("FAIL post_reset_duty: got %0d, expected 8", duty);
      end
   endtask

   task automatic test_jitter();
      bit got;
      jitter_en = 1'b1;
      tb_high   = 300;
      wait_pulses(3, got);
      n_checks++;
      if (!got || $isunknown(duty) || duty < 4'd2 || duty > 4'd4) begin
         n_fail++; $display("FAIL jitter_duty: got %0d, expected 2..4", duty);
      end
      n_checks++;
      if (activo !== 1'b1) begin
         n_fail++; $display("FAIL jitter_activo: got %0b, expected 1", activo);
      end
      jitter_en = 1'b0;
   endtask

   initial begin
      tb_high   = 100;
      gen_start = 1'b1;
      test_reset();
      test_first_window();
      test_duty_levels();
      test_constant();
      test_reset_mid();
      test_jitter();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
